// File: rtl/uart_cmd_responder.sv
// Host command responder between uart_rx and uart_tx2: maps each received byte to a
// response, queues it and transmits it. Define UART_RESP_CRLF_EN to append CR/LF to every response.
module uart_cmd_responder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  ID_BYTE    = 8'h49
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX_DV,
  input  logic [7:0] RX_BYTE,
  output logic       TX_DV,
  output logic [7:0] TX_BYTE,
  input  logic       TX_DONE,
  output logic       BUSY,
  output logic       OVERFLOW,
  output logic [7:0] RX_COUNT
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  CMD_QUERY = 8'h3F;
  localparam logic [7:0]  CMD_COUNT = 8'h21;

  typedef logic [AW:0] ptr_t;

`ifdef UART_RESP_CRLF_EN
  typedef enum logic [3:0] {
    IDLE, SEND, WAIT_DONE, CR, SEND_CR, WAIT_CR, LF, SEND_LF, WAIT_LF
  } state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;
`endif

  state_t     state, state_next;
  logic [7:0] mem [FIFO_DEPTH];
  ptr_t       wr_ptr, rd_ptr;
  logic       empty, full, push, pop, load;
  logic [7:0] load_byte, count_next, mapped;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot the push needs.
  assign push       = RX_DV && (!full || pop);
  assign count_next = RX_COUNT + 8'd1;

  always_comb begin
    case (RX_BYTE)
      CMD_QUERY: mapped = ID_BYTE;
      CMD_COUNT: mapped = count_next;
      default:   mapped = RX_BYTE;
    endcase
  end

  // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= mapped;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      RX_COUNT <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (RX_DV)         RX_COUNT <= count_next;
      if (RX_DV && !push) OVERFLOW <= 1'b1;
      if (push)          wr_ptr   <= wr_ptr + ptr_t'(1);
      if (pop)           rd_ptr   <= rd_ptr + ptr_t'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      TX_BYTE <= '0;
    end else begin
      state <= state_next;
      if (load) TX_BYTE <= load_byte;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    load_byte  = mem[rd_ptr[AW-1:0]];
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND:      state_next = WAIT_DONE;
`ifdef UART_RESP_CRLF_EN
      WAIT_DONE: if (TX_DONE) state_next = CR;
      CR: begin
        load       = 1'b1;
        load_byte  = 8'h0D;
        state_next = SEND_CR;
      end
      SEND_CR:   state_next = WAIT_CR;
      WAIT_CR:   if (TX_DONE) state_next = LF;
      LF: begin
        load       = 1'b1;
        load_byte  = 8'h0A;
        state_next = SEND_LF;
      end
      SEND_LF:   state_next = WAIT_LF;
      WAIT_LF:   if (TX_DONE) state_next = IDLE;
`else
      WAIT_DONE: if (TX_DONE) state_next = IDLE;
`endif
      default:   state_next = IDLE;
    endcase
  end

`ifdef UART_RESP_CRLF_EN
  assign TX_DV = (state == SEND) || (state == SEND_CR) || (state == SEND_LF);
`else
  assign TX_DV = (state == SEND);
`endif
  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: transaction-level model compared every cycle,
// plus directed literal checks of transmitted byte streams. Honors UART_RESP_CRLF_EN.
module tb_uart_cmd_responder;

  localparam int         DEPTH = 8;
  localparam logic [7:0] ID    = 8'h49;
`ifdef UART_RESP_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_done;
  logic       busy;
  logic       overflow;
  logic [7:0] rx_count;

  always #5 clk = ~clk;

  uart_cmd_responder #(.FIFO_DEPTH(DEPTH), .ID_BYTE(ID)) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .RX_DV   (rx_dv),
    .RX_BYTE (rx_byte),
    .TX_DV   (tx_dv),
    .TX_BYTE (tx_byte),
    .TX_DONE (tx_done),
    .BUSY    (busy),
    .OVERFLOW(overflow),
    .RX_COUNT(rx_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model: a queue of pending responses plus the bytes of the response being transmitted.
  logic [7:0] m_q[$];
  logic [7:0] m_trail[$];
  logic [7:0] m_count = 8'h00;
  logic [7:0] m_tx_byte = 8'h00;
  bit m_busy = 1'b0, m_dv = 1'b0, m_wait = 1'b0, m_load = 1'b0, m_ovf = 1'b0;

  initial begin : model
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_q.delete();
        m_trail.delete();
        m_count = 8'h00; m_tx_byte = 8'h00;
        m_busy = 1'b0; m_dv = 1'b0; m_wait = 1'b0; m_load = 1'b0; m_ovf = 1'b0;
      end else begin
        bit dv_next;
        logic [7:0] rsp;
        dv_next = 1'b0;
        if (!m_busy) begin
          if (m_q.size() > 0) begin
            m_tx_byte = m_q.pop_front();
            m_busy    = 1'b1;
            dv_next   = 1'b1;
            if (CRLF) begin
              m_trail.push_back(8'h0D);
              m_trail.push_back(8'h0A);
            end
          end
        end else if (m_dv) begin
          m_wait = 1'b1;
        end else if (m_wait) begin
          if (tx_done) begin
            m_wait = 1'b0;
            if (m_trail.size() > 0) m_load = 1'b1;
            else                    m_busy = 1'b0;
          end
        end else if (m_load) begin
          m_tx_byte = m_trail.pop_front();
          m_load    = 1'b0;
          dv_next   = 1'b1;
        end
        m_dv = dv_next;
        if (rx_dv) begin
          m_count = m_count + 8'd1;
          if (rx_byte == 8'h3F)      rsp = ID;
          else if (rx_byte == 8'h21) rsp = m_count;
          else                       rsp = rx_byte;
          if (m_q.size() < DEPTH) m_q.push_back(rsp);
          else                    m_ovf = 1'b1;
        end
      end
    end
  end

  bit cmp_en = 1'b0;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("tx_dv",    32'(tx_dv),    32'(m_dv));
        check("tx_byte",  32'(tx_byte),  32'(m_tx_byte));
        check("busy",     32'(busy),     32'(m_busy));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rx_count", 32'(rx_count), 32'(m_count));
      end
    end
  end

  // Stand-in for uart_tx2: logs each started byte and answers with TX_DONE after done_gap cycles.
  logic [7:0] tx_log[$];
  bit done_en = 1'b1, stray_req = 1'b0, owed = 1'b0;
  int done_gap = 2, gap_left = 0;

  initial begin : tx_side
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) owed = 1'b0;
      else if (tx_dv) begin
        owed     = 1'b1;
        gap_left = done_gap;
        tx_log.push_back(tx_byte);
      end
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (stray_req) begin
        tx_done   = 1'b1;
        stray_req = 1'b0;
      end else if (owed && done_en) begin
        if (gap_left == 0) begin
          tx_done = 1'b1;
          owed    = 1'b0;
        end else gap_left--;
      end
    end
  end

  logic [7:0] exp_log[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int cyc   = 0;
    while (quiet < 4 && cyc < 3000) begin
      tick();
      cyc++;
      quiet = busy ? 0 : quiet + 1;
    end
    if (quiet < 4) check({name, " drain timeout"}, 32'(cyc), 32'(0));
  endtask

  task automatic expect_rsp(input logic [7:0] b);
    exp_log.push_back(b);
    if (CRLF) begin
      exp_log.push_back(8'h0D);
      exp_log.push_back(8'h0A);
    end
  endtask

  task automatic check_log(input string name);
    check({name, " byte count"}, 32'(tx_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < tx_log.size(); i++)
      check($sformatf("%s byte %0d", name, i), 32'(tx_log[i]), 32'(exp_log[i]));
    tx_log.delete();
    exp_log.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int spacing;
    spacing = CRLF ? 16 : 8;

    repeat (3) tick();
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    check("reset tx_dv",    32'(tx_dv),    32'(0));
    check("reset tx_byte",  32'(tx_byte),  32'(0));
    check("reset busy",     32'(busy),     32'(0));
    check("reset overflow", 32'(overflow), 32'(0));
    check("reset rx_count", 32'(rx_count), 32'(0));

    // Query: TX_DV two edges after the RX_DV edge, carrying ID_BYTE.
    send(8'h3F);
    check("query dv before pop", 32'(tx_dv), 32'(0));
    tick();
    check("query tx_dv",   32'(tx_dv),   32'(1));
    check("query tx_byte", 32'(tx_byte), 32'(8'h49));
    check("query busy",    32'(busy),    32'(1));
    tick();
    check("query single dv", 32'(tx_dv), 32'(0));
    wait_idle("query");
    check("query rx_count", 32'(rx_count), 32'(1));
    expect_rsp(8'h49);
    check_log("query");

    // Echo then count.
    apply_reset();
    send(8'h41);
    send(8'h21);
    wait_idle("echo");
    check("echo rx_count", 32'(rx_count), 32'(2));
    expect_rsp(8'h41);
    expect_rsp(8'h02);
    check_log("echo");

    // Overflow with TX_DONE withheld.
    apply_reset();
    done_en = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(i));
    tick();
    check("ovf overflow", 32'(overflow), 32'(1));
    check("ovf rx_count", 32'(rx_count), 32'(10));
    check("ovf in flight", 32'(tx_byte), 32'(8'h00));
    check("ovf busy", 32'(busy), 32'(1));
    done_en = 1'b1;
    wait_idle("ovf");
    check("ovf sticky", 32'(overflow), 32'(1));
    for (int i = 0; i < 9; i++) expect_rsp(8'(i));
    check_log("ovf");

    // RX_COUNT wrap.
    apply_reset();
    done_gap = 1;
    for (int i = 0; i < 256; i++) begin
      send(8'h55);
      repeat (spacing - 1) tick();
    end
    check("wrap rx_count", 32'(rx_count), 32'(0));
    check("wrap no overflow", 32'(overflow), 32'(0));
    wait_idle("wrap");
    for (int i = 0; i < 256; i++) expect_rsp(8'h55);
    check_log("wrap echoes");
    send(8'h21);
    wait_idle("wrap count");
    check("wrap count after", 32'(rx_count), 32'(1));
    expect_rsp(8'h01);
    check_log("wrap count");

    // Reset during WAIT_DONE with three entries queued.
    apply_reset();
    done_gap = 2;
    done_en  = 1'b0;
    send(8'h10);
    send(8'h11);
    send(8'h12);
    send(8'h13);
    tick();
    check("midrst busy before", 32'(busy), 32'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst busy",     32'(busy),     32'(0));
    check("midrst tx_dv",    32'(tx_dv),    32'(0));
    check("midrst rx_count", 32'(rx_count), 32'(0));
    check("midrst tx_byte",  32'(tx_byte),  32'(0));
    done_en   = 1'b1;
    stray_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("midrst quiet dv %0d", i), 32'(tx_dv), 32'(0));
      check($sformatf("midrst quiet busy %0d", i), 32'(busy), 32'(0));
    end
    exp_log.push_back(8'h10);
    check_log("midrst");

`ifdef UART_RESP_CRLF_EN
    // CR/LF trailer: three separate TX_DV pulses.
    apply_reset();
    done_gap = 3;
    send(8'h3F);
    wait_idle("crlf");
    exp_log.push_back(8'h49);
    exp_log.push_back(8'h0D);
    exp_log.push_back(8'h0A);
    check_log("crlf");
`endif

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Command responder that sits between uart_rx and uart_tx2 and forms the far end of the host-to-FPGA serial link.
- Accepts received bytes (RX_DV/RX_BYTE) and maps each one to a response byte.
- Buffers the responses in a small FIFO and feeds them to uart_tx2 one at a time over the TX_DV/TX_BYTE/DONE handshake.
- Its purpose is to answer host commands, such as the 0x3F query, without any software involvement.

Parameters:
- FIFO_DEPTH, 8, number of response entries; must be a power of two, minimum 2.
- ID_BYTE, 8'h49, response byte returned for the query command 0x3F.

Ports:
- CLK  input  1  system clock, shared with uart_rx and uart_tx2.
- RST_N  input  1  synchronous, active-low reset.
- RX_DV  input  1  one-cycle strobe from uart_rx: RX_BYTE is valid.
- RX_BYTE  input  8  received byte.
- TX_DV  output  1  one-cycle strobe to uart_tx2: start sending TX_BYTE.
- TX_BYTE  output  8  byte to transmit; held stable from the TX_DV cycle until TX_DONE.
- TX_DONE  input  1  one-cycle pulse from uart_tx2 when the stop bit has finished.
- BUSY  output  1  high whenever the state is not IDLE.
- OVERFLOW  output  1  sticky; set when a response is dropped because the FIFO is full.
- RX_COUNT  output  8  count of RX_DV strobes seen since reset; wraps 255 -> 0.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - TX_DV=0, TX_BYTE=0, BUSY=0, OVERFLOW=0, RX_COUNT=0.
  - FIFO is emptied; state goes to IDLE.
  - Reset applies mid-transmission too. Any TX_DONE pulse that arrives afterwards in IDLE is ignored.
- Mapping, done at push time on an RX_DV cycle:
  - RX_COUNT increments first; call the new value C.
  - 0x3F -> ID_BYTE.
  - 0x21 -> C, the post-increment count (the '!' byte is counted).
  - Any other byte -> echoed unchanged.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH).
  - Full when the pointer MSBs differ and the lower bits are equal; empty when the pointers are equal.
  - A push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
  - Otherwise the mapped byte is discarded, OVERFLOW is set, and RX_COUNT still increments.
  - Simultaneous push and pop on an empty FIFO: the push is stored; there is no bypass.
- State machine:
  - IDLE: if the FIFO is non-empty, pop the head into TX_BYTE and go to SEND.
  - SEND: TX_DV=1 for exactly this one cycle; go to WAIT_DONE.
  - WAIT_DONE: hold TX_BYTE; on TX_DONE go to IDLE (or to CR when the optional feature is compiled in).
  - TX_DONE arriving in IDLE or SEND is ignored.
- Latency:
  - RX_DV at edge N -> entry visible at N+1 -> IDLE pops at N+1 -> TX_DV high during cycle N+2 (minimum 2 cycles).
  - Back-to-back responses: the next TX_DV comes 2 cycles after the TX_DONE pulse.
- RX_DV is sampled in every state, so reception never stalls while BUSY is high.

Optional Feature:
- Macro: UART_RESP_CRLF_EN.
- Defined:
  - Every response is followed by 0x0D then 0x0A.
  - Extra states CR, SEND_CR, WAIT_CR, LF, SEND_LF, WAIT_LF; each byte uses its own TX_DV pulse and waits for TX_DONE.
  - The FIFO is not popped until after LF completes; BUSY stays high throughout.
- Undefined: those states do not exist; WAIT_DONE returns directly to IDLE.

Test Plan:
- Query: RX_DV with RX_BYTE=0x3F -> one TX_DV, 2 cycles later, with TX_BYTE=0x49; BUSY high until TX_DONE; RX_COUNT=1.
- Echo then count: send 0x41 then 0x21 -> TX_BYTE 0x41, then 0x02 after the first TX_DONE; RX_COUNT=2.
- Overflow: with TX_DONE withheld, push 10 bytes 0x00..0x09 (depth 8) -> one byte in flight (0x00), FIFO holds 0x01..0x08, byte 0x09 dropped, OVERFLOW=1, RX_COUNT=10. Releasing TX_DONE drains 0x01..0x08 in order.
- Wrap: 256 RX_DV strobes of 0x55 (delivered slowly enough that none are dropped), then 0x21 -> RX_COUNT wraps to 0, then responds 0x01.
- Reset mid-operation: RST_N low during WAIT_DONE with 3 entries queued -> next cycle BUSY=0, TX_DV=0, FIFO empty; a stray TX_DONE afterwards produces no TX_DV.
- CRLF (with UART_RESP_CRLF_EN): send 0x3F -> TX_BYTE sequence 0x49, 0x0D, 0x0A, each with a single TX_DV pulse issued only after the previous TX_DONE.
